// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB encodings and byte-lane helpers shared by the memory responder
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_GNT,
        ARB_GRANTED
    } arb_state_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [31:0] RANGE_ERR_DATA = 32'hDEAD_BEEF;

    // Zero means the burst has no fixed length to police.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_INCR4:  return 5'd4;
            HBURST_INCR8:  return 5'd8;
            HBURST_INCR16: return 5'd16;
            default:       return 5'd0;
        endcase
    endfunction

    function automatic logic [3:0] byte_lanes(input logic [1:0] addr_lo, input logic [2:0] hsize);
        case (hsize)
            HSIZE_BYTE: return 4'b0001 << addr_lo;
            HSIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] new_word,
                                                input logic [3:0] lanes);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = lanes[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_arbiter_1m.sv
// rtl/ahb_arbiter_1m.sv - single-master AHB grant FSM with programmable grant latency
module ahb_arbiter_1m
    import ahb_pkg::*;
#(
    parameter int GRANT_DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic busreq,
    input  logic hold,
    output logic hgrant
);

    arb_state_e state, state_next;
    logic [7:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ARB_IDLE: begin
                if (busreq) begin
                    state_next = ARB_WAIT_GNT;
                    cnt_next   = 8'(GRANT_DLY - 1);
                end
            end
            ARB_WAIT_GNT: begin
                if (!busreq)
                    state_next = ARB_IDLE;
                else if (cnt == 8'd0)
                    state_next = ARB_GRANTED;
                else
                    cnt_next = cnt - 8'd1;
            end
            ARB_GRANTED: begin
                // A stalled data phase keeps the grant so the beat can finish.
                if (!busreq && !hold)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign hgrant = (state == ARB_GRANTED);

endmodule

// File: rtl/ahb_mem_responder.sv
// rtl/ahb_mem_responder.sv - AHB arbiter plus word-addressed memory slave serving the rotation DMA
module ahb_mem_responder
    import ahb_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          GRANT_DLY = 2,
    parameter int          WAIT_NSEQ = 1,
    parameter int          WAIT_SEQ  = 0
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic [31:0] I_AHB_HADDR,
    input  logic [1:0]  I_AHB_HTRANS,
    input  logic [2:0]  I_AHB_HSIZE,
    input  logic [2:0]  I_AHB_HBURST,
    input  logic        I_AHB_HWRITE,
    input  logic [31:0] I_AHB_HWDATA,
    input  logic        I_AHB_HBUSREQ,
    output logic        O_AHB_HGRANT,
    output logic        O_AHB_HREADY,
    output logic [31:0] O_AHB_HRDATA,
    output logic        O_ERR,
    output logic [15:0] O_BEAT_CNT
);

    localparam logic [32:0] SPAN = 33'd1 << (ADDR_W + 2);

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return !off[32] && (off < SPAN);
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[ADDR_W+1:2];
    endfunction

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    logic              hgrant, hready, is_xfer, accept, complete;
    logic              misalign, seq_bad, early_term, no_grant_xfer, set_err;
    logic              dp_valid, dp_write, wr_commit, rd_load;
    logic [31:0]       dp_addr, last_addr, rd_addr, rd_word, wr_merged, hrdata_q;
    logic [2:0]        dp_size;
    logic [7:0]        wcnt, wload;
    logic [4:0]        brem;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic              err_q;
    logic [15:0]       beat_cnt;

    ahb_arbiter_1m #(.GRANT_DLY(GRANT_DLY)) u_arbiter (
        .clk    (I_HCLK),
        .rst    (I_HRESET),
        .busreq (I_AHB_HBUSREQ),
        .hold   (dp_valid && !hready),
        .hgrant (hgrant)
    );

    always_comb begin
        is_xfer  = (I_AHB_HTRANS == HTRANS_NONSEQ) || (I_AHB_HTRANS == HTRANS_SEQ);
        hready   = !dp_valid || (wcnt == 8'd0);
        accept   = hready && hgrant && is_xfer;
        complete = dp_valid && hready;
        wload    = (I_AHB_HTRANS == HTRANS_NONSEQ) ? 8'(WAIT_NSEQ) : 8'(WAIT_SEQ);

        misalign = ((I_AHB_HSIZE == HSIZE_HALF) && I_AHB_HADDR[0]) ||
                   ((I_AHB_HSIZE == HSIZE_WORD) && (I_AHB_HADDR[1:0] != 2'b00));
        seq_bad  = (I_AHB_HTRANS == HTRANS_SEQ) && (I_AHB_HADDR != last_addr + (32'd1 << I_AHB_HSIZE));
        // A fixed-length burst may only be interrupted by BUSY, never by IDLE or a new NONSEQ.
        early_term = hready && hgrant && (brem != 5'd0) &&
                     ((I_AHB_HTRANS == HTRANS_NONSEQ) || (I_AHB_HTRANS == HTRANS_IDLE));
        no_grant_xfer = hready && !hgrant && is_xfer;
        set_err = (accept && (misalign || (I_AHB_HSIZE > HSIZE_WORD) || seq_bad || !in_range(I_AHB_HADDR)))
                  || early_term || no_grant_xfer;

        wr_idx    = word_idx(dp_addr);
        wr_merged = merge_bytes(mem[wr_idx], I_AHB_HWDATA, byte_lanes(dp_addr[1:0], dp_size));
        wr_commit = complete && dp_write && in_range(dp_addr) && (dp_size <= HSIZE_WORD);

        // Read data is captured on the edge that opens the HREADY-high cycle; a zero-wait
        // read accepted alongside a committing write to the same word sees the merged data.
        rd_addr = hready ? I_AHB_HADDR : dp_addr;
        rd_idx  = word_idx(rd_addr);
        rd_load = hready ? (accept && !I_AHB_HWRITE && (wload == 8'd0))
                         : ((wcnt == 8'd1) && !dp_write);
        if (!in_range(rd_addr))
            rd_word = RANGE_ERR_DATA;
        else if (wr_commit && (wr_idx == rd_idx))
            rd_word = wr_merged;
        else
            rd_word = mem[rd_idx];
    end

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_addr   <= 32'd0;
            dp_size   <= 3'd0;
            wcnt      <= 8'd0;
            last_addr <= 32'd0;
            brem      <= 5'd0;
            hrdata_q  <= 32'd0;
            err_q     <= 1'b0;
            beat_cnt  <= 16'd0;
        end else begin
            if (!hready)
                wcnt <= wcnt - 8'd1;
            if (hready)
                dp_valid <= accept;
            if (accept) begin
                dp_addr   <= I_AHB_HADDR;
                dp_size   <= I_AHB_HSIZE;
                dp_write  <= I_AHB_HWRITE;
                wcnt      <= wload;
                last_addr <= I_AHB_HADDR;
            end
            if (accept && (I_AHB_HTRANS == HTRANS_NONSEQ))
                brem <= (burst_len(I_AHB_HBURST) == 5'd0) ? 5'd0 : burst_len(I_AHB_HBURST) - 5'd1;
            else if (accept && (brem != 5'd0))
                brem <= brem - 5'd1;
            else if (hready && hgrant && (I_AHB_HTRANS == HTRANS_IDLE))
                brem <= 5'd0;
            if (complete)
                beat_cnt <= beat_cnt + 16'd1;
            if (rd_load)
                hrdata_q <= rd_word;
            if (set_err)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (wr_commit)
            mem[wr_idx] <= wr_merged;
    end

    assign O_AHB_HGRANT = hgrant;
    assign O_AHB_HREADY = hready;
    assign O_AHB_HRDATA = hrdata_q;
    assign O_ERR        = err_q;
    assign O_BEAT_CNT   = beat_cnt;

endmodule
